// File: rtl/l2_pkg.sv
// Shared types for the ab byte packer: the assembled word, its FIFO entry
// (word plus pad flag) and the pair-phase encoding.
package l2_pkg;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
   } ab;

   typedef struct packed {
      logic pad;
      ab    data;
   } ab_entry_t;

   typedef enum logic {
      PH_A = 1'b0,
      PH_B = 1'b1
   } ab_phase_t;

endpackage

// File: rtl/ab_fifo.sv
// Synchronous FIFO of ab_entry_t. The head entry reads as zero while empty,
// so downstream outputs are clean even though the storage itself is not reset.
module ab_fifo
   import l2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      flush,
   input  logic      push,
   input  ab_entry_t din,
   input  logic      pop,
   output ab_entry_t dout,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   ab_entry_t     mem_q [DEPTH];
   logic          do_push, do_pop;

   assign full    = (cnt_q == FULL_CNT);
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         // Simultaneous push and pop leave the occupancy unchanged.
         if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/ab_byte_packer.sv
// Packs a valid/ready byte stream into {a,b} words; odd-length frames end with
// a PAD_BYTE-filled word flagged by out_pad. Words leave through ab_fifo.
module ab_byte_packer
   import l2_pkg::*;
#(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] PAD_BYTE   = 8'h00,
   parameter int         CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output ab                out_data,
   output logic             out_pad,
   output logic [CNT_W-1:0] word_cnt
);

   ab_phase_t        phase_q, phase_d;
   logic [7:0]       hold_q, hold_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic             fifo_full, fifo_empty, push, pop, beat;
   ab_entry_t        push_entry, fifo_dout;

   // in_ready depends only on FIFO occupancy, never on out_ready.
   assign in_ready  = !fifo_full;
   assign beat      = in_valid && in_ready;
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign out_data  = fifo_dout.data;
   assign out_pad   = fifo_dout.pad;
   assign word_cnt  = word_cnt_q;

   always_comb begin
      phase_d    = phase_q;
      hold_d     = hold_q;
      word_cnt_d = word_cnt_q;
      push       = 1'b0;
      push_entry = '0;
      if (flush) begin
         phase_d    = PH_A;
         hold_d     = '0;
         word_cnt_d = '0;
      end else begin
         if (beat) begin
            case (phase_q)
               PH_A: begin
                  if (in_last) begin
                     push       = 1'b1;
                     push_entry = '{pad: 1'b1, data: '{a: in_data, b: PAD_BYTE}};
                  end else begin
                     hold_d  = in_data;
                     phase_d = PH_B;
                  end
               end
               default: begin
                  push       = 1'b1;
                  push_entry = '{pad: 1'b0, data: '{a: hold_q, b: in_data}};
                  phase_d    = PH_A;
               end
            endcase
         end
         if (push && (word_cnt_q != '1)) word_cnt_d = word_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q    <= PH_A;
         hold_q     <= '0;
         word_cnt_q <= '0;
      end else begin
         phase_q    <= phase_d;
         hold_q     <= hold_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   ab_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .flush(flush),
      .push (push),
      .din  (push_entry),
      .pop  (pop),
      .dout (fifo_dout),
      .full (fifo_full),
      .empty(fifo_empty)
   );

endmodule

// File: tb/tb_ab_byte_packer.sv
// Directed bench for ab_byte_packer with a queue-based reference model and
// per-cycle comparison, plus literal expectations for each scenario.
module tb_ab_byte_packer;
   import l2_pkg::*;

   localparam int         DEPTH   = 4;
   localparam logic [7:0] PAD     = 8'h00;
   localparam int         CNT_W   = 4;
   localparam int         CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       in_data = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   ab                out_data;
   logic             out_pad;
   logic [CNT_W-1:0] word_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // Model state: queue of {pad,a,b}, pending A byte, word counter.
   logic [16:0] mq[$];
   logic [7:0]  m_pend;
   bit          m_have;
   int          m_cnt;
   logic [16:0] got[$];

   ab_byte_packer #(
      .FIFO_DEPTH(DEPTH),
      .PAD_BYTE  (PAD),
      .CNT_W     (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_pad  (out_pad),
      .word_cnt (word_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pop then push, using pre-edge occupancy for in_ready.
   initial begin
      mq.delete(); m_have = 0; m_pend = '0; m_cnt = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n || flush) begin
            mq.delete(); m_have = 0; m_pend = '0; m_cnt = 0;
         end else begin
            bit rdy;
            bit pushed;
            rdy = (mq.size() < DEPTH);
            pushed = 0;
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (in_valid && rdy) begin
               if (m_have) begin
                  mq.push_back({1'b0, m_pend, in_data});
                  m_have = 0;
                  pushed = 1;
               end else if (in_last) begin
                  mq.push_back({1'b1, in_data, PAD});
                  pushed = 1;
               end else begin
                  m_pend = in_data;
                  m_have = 1;
               end
            end
            if (pushed && m_cnt < CNT_MAX) m_cnt++;
         end
      end
   end

   // Record every word the consumer actually takes.
   initial forever begin
      @(posedge clk);
      if (rst_n && !flush && out_valid && out_ready) got.push_back({out_pad, out_data});
   end

   // Per-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
      if (mq.size() != 0) chk("out_word", 32'({out_pad, out_data}), 32'(mq[0]));
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      int n;
      bit acc;
      n = 0;
      in_valid = 1'b1; in_data = d; in_last = l;
      do begin
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) chk("send_timeout", 32'(0), 32'(1));
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      got.delete();
   endtask

   task automatic chk_got(input string name, input logic [16:0] exp[$]);
      chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
      foreach (exp[i]) if (i < got.size()) chk(name, 32'(got[i]), 32'(exp[i]));
   endtask

   initial begin
      logic [16:0] e[$];

      // Reset values
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_word_cnt", 32'(word_cnt), 32'(0));
      chk("rst_out_word", 32'({out_pad, out_data}), 32'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1);

      // 1: even frame
      out_ready = 1'b1;
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
      step(3);
      e = '{17'h01122, 17'h03344};
      chk_got("t1_words", e);
      chk("t1_word_cnt", 32'(word_cnt), 32'(2));

      // 2: odd frame gets padded
      do_flush();
      send(8'h55, 0); send(8'h66, 0); send(8'h77, 1);
      step(3);
      e = '{17'h05566, {1'b1, 8'h77, PAD}};
      chk_got("t2_words", e);
      chk("t2_word_cnt", 32'(word_cnt), 32'(2));

      // 3: backpressure, 8 pairs into a 4-deep FIFO
      do_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(8'(2*i+1), 0); send(8'(2*i+2), 0);
      end
      chk("t3_in_ready_full", 32'(in_ready), 32'(0));
      fork
         for (int i = 4; i < 8; i++) begin
            send(8'(2*i+1), 0); send(8'(2*i+2), 0);
         end
         begin
            step(5);
            chk("t3_no_pop", 32'(got.size()), 32'(0));
            out_ready = 1'b1;
         end
      join
      step(6);
      e.delete();
      for (int i = 0; i < 8; i++) e.push_back({1'b0, 8'(2*i+1), 8'(2*i+2)});
      chk_got("t3_words", e);
      chk("t3_word_cnt", 32'(word_cnt), 32'(8));

      // 4: full FIFO, pop and offered byte in the same cycle
      do_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(8'(2*i+1), 0); send(8'(2*i+2), 0);
      end
      in_valid = 1'b1; in_data = 8'hE1; out_ready = 1'b1;
      step(1);
      in_valid = 1'b0; out_ready = 1'b0;
      chk("t4_in_ready_after_pop", 32'(in_ready), 32'(1));
      chk("t4_no_push", 32'(word_cnt), 32'(4));
      e = '{17'h00102};
      chk_got("t4_popped", e);

      // 5: flush while an A byte is held
      do_flush();
      out_ready = 1'b1;
      send(8'hAA, 0);
      do_flush();
      chk("t5_empty", 32'(out_valid), 32'(0));
      chk("t5_cnt_clear", 32'(word_cnt), 32'(0));
      send(8'hBB, 0); send(8'hCC, 1);
      step(3);
      e = '{17'h0BBCC};
      chk_got("t5_words", e);

      // 6: asynchronous reset mid-pair with data waiting
      do_flush();
      out_ready = 1'b0;
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", 32'(out_valid), 32'(0));
      chk("t6_rst_in_ready", 32'(in_ready), 32'(1));
      chk("t6_rst_word_cnt", 32'(word_cnt), 32'(0));
      step(2);
      rst_n = 1'b1;
      got.delete();
      out_ready = 1'b1;
      send(8'h01, 0); send(8'h02, 1);
      step(3);
      e = '{17'h00102};
      chk_got("t6_words", e);

      // 7: word counter saturates instead of wrapping
      do_flush();
      for (int i = 0; i < CNT_MAX + 2; i++) send(8'(i), 1);
      step(3);
      chk("t7_cnt_sat", 32'(word_cnt), 32'(CNT_MAX));
      chk("t7_len", 32'(got.size()), 32'(CNT_MAX + 2));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
